ccff_frame_loader: RTL and testbench



---
 rtl/ccff_frame_loader_if.sv | 29 ++
 rtl/ccff_frame_loader.sv | 108 ++++++++++
 tb/tb_ccff_frame_loader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ccff_frame_loader_if.sv
// rtl/ccff_frame_loader_if.sv - configuration frame stream interface
// Purpose: groups the frame-load handshake and status signals.
// Signals:
//   cfg_start  frame start/restart pulse (master -> slave)
//   cfg_data   frame word, data words then parity word (master -> slave)
//   cfg_valid  cfg_data valid (master -> slave)
//   cfg_ready  loader accepts a word (slave -> master)
//   cfg_done   frame committed (slave -> master)
//   cfg_err    parity mismatch seen (slave -> master)
interface ccff_frame_loader_if #(
  parameter int WORD_W = 8
);
  logic              cfg_start;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              cfg_done;
  logic              cfg_err;

  modport master (
    output cfg_start, cfg_data, cfg_valid,
    input  cfg_ready, cfg_done, cfg_err
  );

  modport slave (
    input  cfg_start, cfg_data, cfg_valid,
    output cfg_ready, cfg_done, cfg_err
  );
endinterface

// File: rtl/ccff_frame_loader.sv
// rtl/ccff_frame_loader.sv - parity-checked configuration frame loader for mux selects
// Purpose: collects a frame of WORD_W-bit words plus a parity word into a shadow
// register and commits it to mem/mem_inv in one cycle after a good parity check.
// Ports:
//   prog_clk  configuration clock, rising edge
//   pReset_n  synchronous active-low reset
//   cfg       frame stream interface (slave side)
//   mem       committed configuration bits, mem[0] = bit 0 of word 0
//   mem_inv   bitwise complement of mem
module ccff_frame_loader #(
  parameter int NUM_MEM = 20,
  parameter int WORD_W  = 8
) (
  input  logic                  prog_clk,
  input  logic                  pReset_n,
  ccff_frame_loader_if.slave    cfg,
  output logic [0:NUM_MEM-1]    mem,
  output logic [0:NUM_MEM-1]    mem_inv
);

  localparam int NWORDS = (NUM_MEM + WORD_W - 1) / WORD_W;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CHECK  = 3'd2,
    COMMIT = 3'd3,
    ERR    = 3'd4
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [WORD_W-1:0]  acc;
  logic [0:NUM_MEM-1] shadow;
  logic [0:NUM_MEM-1] mem_q;
  logic               done_q;
  logic               err_q;
  logic               hs;

  assign cfg.cfg_ready = (state == LOAD) || (state == CHECK);
  assign hs            = cfg.cfg_valid && cfg.cfg_ready;
  assign cfg.cfg_done  = done_q;
  assign cfg.cfg_err   = err_q;

  // Both select polarities come from the same flops, so they can never disagree.
  assign mem     = mem_q;
  assign mem_inv = ~mem_q;

  always_ff @(posedge prog_clk) begin
    if (!pReset_n) begin
      state  <= IDLE;
      count  <= '0;
      acc    <= '0;
      shadow <= '0;
      mem_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (cfg.cfg_start) begin
      // Start wins over everything, including a same-cycle handshake and a pending commit.
      state  <= LOAD;
      count  <= '0;
      acc    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        LOAD: begin
          if (hs) begin
            for (int k = 0; k < NWORDS; k++) begin
              for (int j = 0; j < WORD_W; j++) begin
                // Bits beyond NUM_MEM in the last word are dropped from the shadow,
                // but still take part in the parity accumulation below.
                if ((k * WORD_W + j < NUM_MEM) && (count == CNT_W'(k))) begin
                  shadow[k*WORD_W+j] <= cfg.cfg_data[j];
                end
              end
            end
            acc   <= acc ^ cfg.cfg_data;
            count <= count + 1'b1;
            if (count == CNT_W'(NWORDS - 1)) begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (hs) begin
            if (cfg.cfg_data == acc) begin
              state <= COMMIT;
            end else begin
              state <= ERR;
              err_q <= 1'b1;
            end
          end
        end
        COMMIT: begin
          mem_q  <= shadow;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        ERR: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_frame_loader.sv
// tb/tb_ccff_frame_loader.sv - self-checking bench for ccff_frame_loader
module tb_ccff_frame_loader;

  logic        prog_clk;
  logic        pReset_n;
  logic [0:19] mem_q;
  logic [0:19] mem_inv_q;

  int total;
  int bad;

  ccff_frame_loader_if #(.WORD_W(8)) cfg_if ();

  ccff_frame_loader #(.NUM_MEM(20), .WORD_W(8)) dut (
    .prog_clk (prog_clk),
    .pReset_n (pReset_n),
    .cfg      (cfg_if.slave),
    .mem      (mem_q),
    .mem_inv  (mem_inv_q)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  typedef struct {
    logic [7:0]  w0, w1, w2, par;
    logic        gap;
    logic        exp_done;
    logic        exp_err;
    logic [19:0] exp_mem;   // bit i = mem[i]
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [19:0] mem_val();
    logic [19:0] m;
    for (int i = 0; i < 20; i++) m[i] = mem_q[i];
    return m;
  endfunction

  function automatic logic [19:0] mem_inv_val();
    logic [19:0] m;
    for (int i = 0; i < 20; i++) m[i] = mem_inv_q[i];
    return m;
  endfunction

  task automatic check_mem(input string name, input logic [19:0] exp);
    chk({name, "_mem"}, {12'h0, mem_val()}, {12'h0, exp});
    chk({name, "_mem_inv"}, {12'h0, mem_inv_val()}, {12'h0, ~exp});
  endtask

  task automatic pulse_start();
    cfg_if.cfg_start = 1'b1;
    tick();
    cfg_if.cfg_start = 1'b0;
  endtask

  // Presents one word and returns just after its handshake edge.
  task automatic send_word(input logic [7:0] d);
    int n;
    n = 0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = d;
    while (!cfg_if.cfg_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
    tick();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic gap_cycles();
    cfg_if.cfg_valid = 1'b0;
    tick();
    tick();
  endtask

  // Full frame; returns one edge after the parity handshake (end of COMMIT).
  task automatic run_frame(input logic [7:0] w0, w1, w2, p, input logic gap);
    pulse_start();
    send_word(w0);
    if (gap) gap_cycles();
    send_word(w1);
    if (gap) gap_cycles();
    send_word(w2);
    if (gap) gap_cycles();
    send_word(p);
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cfg_if.cfg_start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = 8'h00;
    pReset_n = 1'b0;

    //              w0     w1     w2     par    gap   done  err   mem
    vecs[0] = '{8'hA5, 8'h3C, 8'hF9, 8'h61, 1'b0, 1'b0, 1'b1, 20'h00000};
    vecs[1] = '{8'hA5, 8'h3C, 8'hF9, 8'h60, 1'b0, 1'b1, 1'b0, 20'h93CA5};
    vecs[2] = '{8'h11, 8'h22, 8'h33, 8'h00, 1'b0, 1'b1, 1'b0, 20'h32211};
    vecs[3] = '{8'h00, 8'h00, 8'hF0, 8'hF0, 1'b0, 1'b1, 1'b0, 20'h00000};
    vecs[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 20'hFFFFF};
    vecs[5] = '{8'h12, 8'h34, 8'h56, 8'h00, 1'b0, 1'b0, 1'b1, 20'hFFFFF};
    vecs[6] = '{8'h12, 8'h34, 8'h56, 8'h70, 1'b1, 1'b1, 1'b0, 20'h63412};
    vecs[7] = '{8'hA5, 8'h3C, 8'hF9, 8'h60, 1'b1, 1'b1, 1'b0, 20'h93CA5};

    tick();
    tick();
    check_mem("reset", 20'h00000);
    chk("reset_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
    chk("reset_done",  {31'd0, cfg_if.cfg_done},  32'd0);
    chk("reset_err",   {31'd0, cfg_if.cfg_err},   32'd0);
    pReset_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      run_frame(vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].par, vecs[i].gap);
      chk($sformatf("v%0d_done", i), {31'd0, cfg_if.cfg_done}, {31'd0, vecs[i].exp_done});
      chk($sformatf("v%0d_err", i),  {31'd0, cfg_if.cfg_err},  {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_ready", i), {31'd0, cfg_if.cfg_ready}, 32'd0);
      check_mem($sformatf("v%0d", i), vecs[i].exp_mem);
      tick();
    end

    // ERR holds ready low and ignores offered words until the next start.
    run_frame(8'h01, 8'h02, 8'h03, 8'h55, 1'b0);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = 8'h00;
    for (int i = 0; i < 3; i++) tick();
    chk("err_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
    chk("err_hold",  {31'd0, cfg_if.cfg_err},   32'd1);
    cfg_if.cfg_valid = 1'b0;
    check_mem("err_keep", 20'h93CA5);

    // Commit latency: nothing visible right after the parity handshake edge.
    pulse_start();
    chk("start_clears_err", {31'd0, cfg_if.cfg_err}, 32'd0);
    send_word(8'h11);
    send_word(8'h22);
    send_word(8'h33);
    send_word(8'h00);
    chk("lat_done_early", {31'd0, cfg_if.cfg_done}, 32'd0);
    check_mem("lat_early", 20'h93CA5);
    tick();
    chk("lat_done", {31'd0, cfg_if.cfg_done}, 32'd1);
    check_mem("lat", 20'h32211);

    // Abort: start coincides with the second word's handshake.
    run_frame(8'h12, 8'h34, 8'h56, 8'h70, 1'b0);
    pulse_start();
    send_word(8'hAA);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = 8'hBB;
    cfg_if.cfg_start = 1'b1;
    tick();
    cfg_if.cfg_start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    chk("abort_done", {31'd0, cfg_if.cfg_done}, 32'd0);
    check_mem("abort_keep", 20'h63412);
    send_word(8'h11);
    send_word(8'h22);
    send_word(8'h33);
    send_word(8'h00);
    tick();
    chk("abort_commit_done", {31'd0, cfg_if.cfg_done}, 32'd1);
    check_mem("abort_commit", 20'h32211);

    // Reset mid-load after a committed frame.
    run_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    pulse_start();
    send_word(8'h5A);
    pReset_n = 1'b0;
    tick();
    check_mem("midrst", 20'h00000);
    chk("midrst_ready", {31'd0, cfg_if.cfg_ready}, 32'd0);
    chk("midrst_done",  {31'd0, cfg_if.cfg_done},  32'd0);
    pReset_n = 1'b1;
    tick();
    run_frame(8'h12, 8'h34, 8'h56, 8'h70, 1'b0);
    chk("post_rst_done", {31'd0, cfg_if.cfg_done}, 32'd1);
    check_mem("post_rst", 20'h63412);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
